// File: rtl/load_store_unit.sv
// Load/store unit: moves one load or store per request between the pipeline and a
// single-outstanding memory port, handling lane steering, extension and bus faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] LoadData,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;

  logic        req, illegal, misaligned, timeout;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req     = MemRead | MemWrite;
  assign timeout = (cnt_q == 8'(TIMEOUT - 1));

  // Decode the incoming request; illegal takes priority over misaligned.
  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite) begin
      illegal = 1'b1;
    end else if (MemRead) begin
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
    misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                 ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  end

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = ReadData2;
    unique case (funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ALUResult[1:0];
        st_wdata = {4{ReadData2[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
        st_wdata = {2{ReadData2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (addr_lo_q)
      2'b00: ld_byte = mem_rdata[7:0];
      2'b01: ld_byte = mem_rdata[15:8];
      2'b10: ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = (illegal || misaligned) ? StDone : StWait;
      StWait:  if (mem_ack || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall      = ((state_q == StIdle) && req) || (state_q == StWait);
    fault      = (state_q == StDone) && (fault_code_q != 2'b00);
    fault_code = (state_q == StDone) ? fault_code_q : 2'b00;
    mem_req    = mem_req_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_wstrb  = mem_wstrb_q;
    LoadData   = load_data_q;
  end

  always_comb begin
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    load_data_d  = load_data_q;
    fault_code_d = fault_code_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_lo_d = ALUResult[1:0];
          funct3_d  = funct3;
          is_load_d = MemRead;
          if (illegal) begin
            fault_code_d = 2'b10;
          end else if (misaligned) begin
            fault_code_d = 2'b01;
          end else begin
            cnt_d       = 8'h00;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {ALUResult[31:2], 2'b00};
            mem_wdata_d = MemWrite ? st_wdata : 32'h0;
            mem_wstrb_d = MemWrite ? st_wstrb : 4'h0;
          end
        end
      end
      StWait: begin
        if (mem_ack || timeout) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = 32'h0;
          mem_wstrb_d = 4'h0;
          if (mem_ack) begin
            if (is_load_q) load_data_d = ld_ext;
          end else begin
            fault_code_d = 2'b11;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: fault_code_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 8'h00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      load_data_q  <= 32'h0;
      fault_code_q <= 2'b00;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      is_load_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      load_data_q  <= load_data_d;
      fault_code_q <= fault_code_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for each access type,
// fault path, timeout race and mid-transaction reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] ReadData2 = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req, mem_we, stall, fault;
  logic [31:0] mem_addr, mem_wdata, LoadData;
  logic [3:0]  mem_wstrb;
  logic [1:0]  fault_code;

  int checks = 0;
  int failures = 0;
  int n;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .LoadData(LoadData), .stall(stall), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; ReadData2 = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_load_data", LoadData, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_stall", stall, 0);
    step();
    rst_n = 1'b1;

    // LB at 0x1003, zero-wait memory
    drive(1, 0, 3'b000, 32'h1003, 0);
    #1 chk("lb_stall_idle", stall, 1);
    chk("lb_no_req_idle", mem_req, 0);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("lb_req", mem_req, 1);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_we", mem_we, 0);
    chk("lb_stall_wait", stall, 1);
    mem_ack = 1'b1; mem_rdata = 32'h80AB_CDEF;
    step();
    mem_ack = 1'b0;
    chk("lb_load_data", LoadData, 32'hFFFF_FF80);
    chk("lb_stall_done", stall, 0);
    chk("lb_req_done", mem_req, 0);
    chk("lb_fault", fault, 0);
    step();

    // SH at 0x2002, ack on third WAIT cycle
    drive(0, 1, 3'b001, 32'h2002, 32'h0000_1234);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_we", mem_we, 1);
    step();
    chk("sh_hold_wstrb", mem_wstrb, 4'b1100);
    step();
    chk("sh_hold_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    chk("sh_load_data_kept", LoadData, 32'hFFFF_FF80);
    chk("sh_wstrb_cleared", mem_wstrb, 0);
    chk("sh_we_cleared", mem_we, 0);
    step();

    // LW misaligned at 0x3001
    drive(1, 0, 3'b010, 32'h3001, 0);
    #1 chk("lw_mis_stall", stall, 1);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("lw_mis_req", mem_req, 0);
    chk("lw_mis_fault", fault, 1);
    chk("lw_mis_code", fault_code, 2'b01);
    step();
    chk("lw_mis_fault_clr", fault, 0);
    chk("lw_mis_code_clr", fault_code, 0);

    // LHU at 0x4000, no ack: times out after 16 request cycles
    drive(1, 0, 3'b101, 32'h4000, 0);
    step();
    drive(0, 0, 3'b000, 0, 0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 16);
    chk("to_code", fault_code, 2'b11);
    chk("to_fault", fault, 1);
    chk("to_load_data_kept", LoadData, 32'hFFFF_FF80);
    step();

    // LHU at 0x4002, ack arrives on the timeout cycle: ack wins
    drive(1, 0, 3'b101, 32'h4002, 0);
    step();
    drive(0, 0, 3'b000, 0, 0);
    repeat (15) step();
    chk("race_req_still", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_1234;
    step();
    mem_ack = 1'b0;
    chk("race_fault", fault, 0);
    chk("race_code", fault_code, 0);
    chk("race_load_data", LoadData, 32'h0000_BEEF);
    step();

    // SW at 0x5000, reset during second WAIT cycle
    drive(0, 1, 3'b010, 32'h5000, 32'hCAFE_F00D);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    step();
    #2 rst_n = 1'b0;
    #1 chk("rst_async_req", mem_req, 0);
    chk("rst_async_we", mem_we, 0);
    chk("rst_async_wstrb", mem_wstrb, 0);
    chk("rst_async_load", LoadData, 0);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    chk("post_rst_ack_req", mem_req, 0);
    chk("post_rst_ack_stall", stall, 0);
    chk("post_rst_ack_load", LoadData, 0);
    mem_ack = 1'b0;

    // MemRead and MemWrite together: illegal
    drive(1, 1, 3'b010, 32'h6000, 32'h0);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("ill_req", mem_req, 0);
    chk("ill_code", fault_code, 2'b10);
    chk("ill_fault", fault, 1);
    step();

    // LB at 0x7001 positive byte, then SB lane steering
    drive(1, 0, 3'b000, 32'h7001, 0);
    step();
    drive(0, 0, 3'b000, 0, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_7F00;
    step();
    mem_ack = 1'b0;
    chk("lb_pos_load", LoadData, 32'h0000_007F);
    step();
    drive(0, 1, 3'b000, 32'h8002, 32'h0000_00A5);
    step();
    drive(0, 0, 3'b000, 0, 0);
    chk("sb_wstrb", mem_wstrb, 4'b0100);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
